// File: rtl/verificador_ataque.sv
// Attack-phase referee for the 5x7 ship map: snapshots the map on iniciar,
// then classifies each fire-button edge and tracks shot mask, counters and game state.
//
// state   | meaning
// OCIOSO  | no game loaded since reset
// JOGANDO | game running, shots are resolved
// VITORIA | every ship cell hit, frozen until iniciar
// DERROTA | MAX_ERROS misses reached, frozen until iniciar
module verificador_ataque #(
    parameter int MAX_ERROS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic [6:0] mapa0,
    input  logic [6:0] mapa1,
    input  logic [6:0] mapa2,
    input  logic [6:0] mapa3,
    input  logic [6:0] mapa4,
    input  logic       atirar,
    input  logic [2:0] linha,
    input  logic [2:0] coluna,
    output logic       acerto,
    output logic       erro,
    output logic       repetido,
    output logic       invalido,
    output logic [6:0] tiros0,
    output logic [6:0] tiros1,
    output logic [6:0] tiros2,
    output logic [6:0] tiros3,
    output logic [6:0] tiros4,
    output logic [5:0] acertos,
    output logic [2:0] erros,
    output logic [5:0] restantes,
    output logic [1:0] estado,
    output logic       venceu,
    output logic       perdeu
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        JOGANDO = 2'b01,
        VITORIA = 2'b10,
        DERROTA = 2'b11
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [34:0] mapa_q, mapa_d;
    logic [34:0] tiros_q, tiros_d;
    logic        atirar_q, atirar_d;
    logic        acerto_q, acerto_d;
    logic        erro_q, erro_d;
    logic        repetido_q, repetido_d;
    logic        invalido_q, invalido_d;
    logic [5:0]  acertos_q, acertos_d;
    logic [2:0]  erros_q, erros_d;
    logic [5:0]  restantes_q, restantes_d;
    logic        venceu_q, venceu_d;
    logic        perdeu_q, perdeu_d;

    logic [34:0] mapa_in;
    logic [5:0]  carga;
    logic [5:0]  alvo;
    logic        disparo;

    // Flat cell index r*7+c matches the row/column layout of the map inputs.
    assign mapa_in = {mapa4, mapa3, mapa2, mapa1, mapa0};
    assign alvo    = 6'(linha) * 6'd7 + 6'(coluna);
    assign disparo = atirar & ~atirar_q;

    always_comb begin
        carga = '0;
        for (int i = 0; i < 35; i++) begin
            carga = carga + 6'(mapa_in[i]);
        end
    end

    always_comb begin
        estado_d    = estado_q;
        mapa_d      = mapa_q;
        tiros_d     = tiros_q;
        atirar_d    = atirar;
        acerto_d    = 1'b0;
        erro_d      = 1'b0;
        repetido_d  = 1'b0;
        invalido_d  = 1'b0;
        acertos_d   = acertos_q;
        erros_d     = erros_q;
        restantes_d = restantes_q;

        if (iniciar) begin
            mapa_d      = mapa_in;
            tiros_d     = '0;
            acertos_d   = '0;
            erros_d     = '0;
            restantes_d = carga;
            estado_d    = JOGANDO;
        end else if (estado_q == JOGANDO) begin
            if (restantes_q == 6'd0) begin
                estado_d = VITORIA;
            end else if (disparo) begin
                if (linha > 3'd4 || coluna > 3'd6) begin
                    invalido_d = 1'b1;
                end else if (tiros_q[alvo]) begin
                    repetido_d = 1'b1;
                end else if (mapa_q[alvo]) begin
                    acerto_d       = 1'b1;
                    tiros_d[alvo]  = 1'b1;
                    acertos_d      = acertos_q + 6'd1;
                    restantes_d    = restantes_q - 6'd1;
                    if (restantes_q == 6'd1) begin
                        estado_d = VITORIA;
                    end
                end else begin
                    erro_d        = 1'b1;
                    tiros_d[alvo] = 1'b1;
                    erros_d       = erros_q + 3'd1;
                    if (erros_d == 3'(MAX_ERROS)) begin
                        estado_d = DERROTA;
                    end
                end
            end
        end

        venceu_d = (estado_d == VITORIA);
        perdeu_d = (estado_d == DERROTA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            mapa_q      <= '0;
            tiros_q     <= '0;
            atirar_q    <= 1'b0;
            acerto_q    <= 1'b0;
            erro_q      <= 1'b0;
            repetido_q  <= 1'b0;
            invalido_q  <= 1'b0;
            acertos_q   <= '0;
            erros_q     <= '0;
            restantes_q <= '0;
            venceu_q    <= 1'b0;
            perdeu_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            mapa_q      <= mapa_d;
            tiros_q     <= tiros_d;
            atirar_q    <= atirar_d;
            acerto_q    <= acerto_d;
            erro_q      <= erro_d;
            repetido_q  <= repetido_d;
            invalido_q  <= invalido_d;
            acertos_q   <= acertos_d;
            erros_q     <= erros_d;
            restantes_q <= restantes_d;
            venceu_q    <= venceu_d;
            perdeu_q    <= perdeu_d;
        end
    end

    assign acerto    = acerto_q;
    assign erro      = erro_q;
    assign repetido  = repetido_q;
    assign invalido  = invalido_q;
    assign tiros0    = tiros_q[6:0];
    assign tiros1    = tiros_q[13:7];
    assign tiros2    = tiros_q[20:14];
    assign tiros3    = tiros_q[27:21];
    assign tiros4    = tiros_q[34:28];
    assign acertos   = acertos_q;
    assign erros     = erros_q;
    assign restantes = restantes_q;
    assign estado    = estado_q;
    assign venceu    = venceu_q;
    assign perdeu    = perdeu_q;

endmodule

// File: tb/tb_verificador_ataque.sv
// Bench for verificador_ataque: directed game scenarios followed by random play,
// every output compared after each edge against a cell-array model of the game rules.
module tb_verificador_ataque;

    localparam int MAXE = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iniciar = 1'b0;
    logic [6:0] mapa [5];
    logic       atirar = 1'b0;
    logic [2:0] linha = '0;
    logic [2:0] coluna = '0;
    logic       acerto, erro, repetido, invalido;
    logic [6:0] tiros0, tiros1, tiros2, tiros3, tiros4;
    logic [5:0] acertos, restantes;
    logic [2:0] erros;
    logic [1:0] estado;
    logic       venceu, perdeu;

    int total = 0;
    int passed = 0;

    verificador_ataque #(.MAX_ERROS(MAXE)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar),
        .mapa0(mapa[0]), .mapa1(mapa[1]), .mapa2(mapa[2]), .mapa3(mapa[3]), .mapa4(mapa[4]),
        .atirar(atirar), .linha(linha), .coluna(coluna),
        .acerto(acerto), .erro(erro), .repetido(repetido), .invalido(invalido),
        .tiros0(tiros0), .tiros1(tiros1), .tiros2(tiros2), .tiros3(tiros3), .tiros4(tiros4),
        .acertos(acertos), .erros(erros), .restantes(restantes), .estado(estado),
        .venceu(venceu), .perdeu(perdeu)
    );

    always #5 clk = ~clk;

    // Game model: ship and shot grids, counters, state as 0 idle / 1 play / 2 win / 3 lose.
    bit m_ship [5][7];
    bit m_shot [5][7];
    int m_hits, m_miss, m_rem, m_st;
    bit m_prev;
    bit p_ac, p_er, p_rep, p_inv;

    task automatic model_reset();
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 7; k++) begin
                m_ship[r][k] = 0;
                m_shot[r][k] = 0;
            end
        m_hits = 0; m_miss = 0; m_rem = 0; m_st = 0; m_prev = 0;
        p_ac = 0; p_er = 0; p_rep = 0; p_inv = 0;
    endtask

    task automatic model_edge(input bit ini, input bit at, input int l, input int c);
        bit fire;
        fire = at && !m_prev;
        m_prev = at;
        p_ac = 0; p_er = 0; p_rep = 0; p_inv = 0;
        if (ini) begin
            m_rem = 0;
            for (int r = 0; r < 5; r++)
                for (int k = 0; k < 7; k++) begin
                    m_ship[r][k] = mapa[r][k];
                    m_shot[r][k] = 0;
                    if (m_ship[r][k]) m_rem++;
                end
            m_hits = 0; m_miss = 0; m_st = 1;
        end else if (m_st == 1) begin
            if (m_rem == 0) m_st = 2;
            else if (fire) begin
                if (l > 4 || c > 6) p_inv = 1;
                else if (m_shot[l][c]) p_rep = 1;
                else if (m_ship[l][c]) begin
                    p_ac = 1; m_shot[l][c] = 1; m_hits++; m_rem--;
                    if (m_rem == 0) m_st = 2;
                end else begin
                    p_er = 1; m_shot[l][c] = 1; m_miss++;
                    if (m_miss == MAXE) m_st = 3;
                end
            end
        end
    endtask

    function automatic logic [6:0] shot_row(input int r);
        logic [6:0] v;
        v = '0;
        for (int k = 0; k < 7; k++) v[k] = m_shot[r][k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".acerto"}, 8'(acerto), 8'(p_ac));
        chk({tag, ".erro"}, 8'(erro), 8'(p_er));
        chk({tag, ".repetido"}, 8'(repetido), 8'(p_rep));
        chk({tag, ".invalido"}, 8'(invalido), 8'(p_inv));
        chk({tag, ".tiros0"}, 8'(tiros0), 8'(shot_row(0)));
        chk({tag, ".tiros1"}, 8'(tiros1), 8'(shot_row(1)));
        chk({tag, ".tiros2"}, 8'(tiros2), 8'(shot_row(2)));
        chk({tag, ".tiros3"}, 8'(tiros3), 8'(shot_row(3)));
        chk({tag, ".tiros4"}, 8'(tiros4), 8'(shot_row(4)));
        chk({tag, ".acertos"}, 8'(acertos), 8'(m_hits));
        chk({tag, ".erros"}, 8'(erros), 8'(m_miss));
        chk({tag, ".restantes"}, 8'(restantes), 8'(m_rem));
        chk({tag, ".estado"}, 8'(estado), 8'(m_st));
        chk({tag, ".venceu"}, 8'(venceu), 8'(m_st == 2));
        chk({tag, ".perdeu"}, 8'(perdeu), 8'(m_st == 3));
    endtask

    task automatic step(input string tag, input bit ini, input bit at, input int l, input int c);
        @(negedge clk);
        iniciar = ini; atirar = at; linha = 3'(l); coluna = 3'(c);
        @(posedge clk);
        model_edge(ini, at, l, c);
        #1;
        check_all(tag);
    endtask

    // A shot is a press step followed by a release step.
    task automatic shoot(input string tag, input int l, input int c);
        step(tag, 0, 1, l, c);
        step({tag, ".rel"}, 0, 0, l, c);
    endtask

    task automatic load_map1();
        mapa[0] = 7'b0000100; mapa[1] = 7'b0001100; mapa[2] = 7'b1000101;
        mapa[3] = 7'b1110001; mapa[4] = 7'b1000011;
    endtask

    initial begin
        int pulses;
        for (int r = 0; r < 5; r++) mapa[r] = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load and hit
        load_map1();
        step("load1", 1, 0, 0, 0);
        chk("load1.rem13", 8'(restantes), 8'd13);
        mapa[0] = 7'b1111111;
        step("hit02", 0, 1, 0, 2);
        chk("hit02.tiros0", 8'(tiros0), 8'b0000100);
        step("hit02.rel", 0, 0, 0, 2);

        // Miss, repeat, invalid
        shoot("miss00", 0, 0);
        shoot("rep00", 0, 0);
        shoot("inv50", 5, 0);
        shoot("inv07", 0, 7);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step("hold", 0, 1, 1, 0);
            pulses += int'(acerto) + int'(erro) + int'(repetido) + int'(invalido);
        end
        chk("hold.pulses", 8'(pulses), 8'd1);
        step("hold.rel", 0, 0, 1, 0);

        // Victory
        for (int r = 0; r < 5; r++) mapa[r] = '0;
        mapa[0] = 7'b0000001;
        step("load_win", 1, 0, 0, 0);
        shoot("win", 0, 0);
        chk("win.estado", 8'(estado), 8'b10);
        shoot("after_win", 1, 1);

        // Empty map
        for (int r = 0; r < 5; r++) mapa[r] = '0;
        step("load_empty", 1, 0, 0, 0);
        step("empty_win", 0, 0, 0, 0);

        // Defeat
        load_map1();
        step("load_def", 1, 0, 0, 0);
        shoot("def1", 0, 0);
        shoot("def2", 0, 1);
        shoot("def3", 0, 3);
        shoot("def4", 0, 4);
        step("def5", 0, 1, 0, 5);
        chk("def5.estado", 8'(estado), 8'b11);
        step("def5.rel", 0, 0, 0, 5);
        shoot("after_def", 0, 6);
        step("restart", 1, 0, 0, 0);

        // Simultaneous iniciar and fresh shot, then the held button stays quiet
        shoot("pre_sim", 2, 0);
        step("sim", 1, 1, 0, 2);
        step("sim.held", 0, 1, 0, 2);
        step("sim.rel", 0, 0, 0, 2);

        // Reset mid-game, mid-pulse
        shoot("r_hit1", 0, 2);
        shoot("r_hit2", 1, 2);
        shoot("r_hit3", 1, 3);
        step("r_hit4", 0, 1, 2, 0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        atirar = 1'b0;
        shoot("post_rst1", 0, 2);
        shoot("post_rst2", 3, 0);

        // Random play
        for (int i = 0; i < 400; i++) begin
            bit ini;
            ini = ($urandom_range(0, 29) == 0);
            for (int r = 0; r < 5; r++) begin
                if ($urandom_range(0, 1) == 1) mapa[r] = 7'($urandom & $urandom & $urandom);
                else mapa[r] = 7'($urandom);
            end
            step("rand", ini, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/verificador_ataque.md
# verificador_ataque

Consumes the 5×7 ship map that the map selector produces and plays the attack phase against it. On `iniciar` it snapshots the five map rows and clears its state. It then resolves each `atirar` press at (`linha`, `coluna`) as hit, miss, repeat or invalid, tracks the shot mask and counters, and declares victory or defeat. It sits between the map selector and the display/score logic of the game top level.

## Interface
- `MAX_ERROS`, default 5: misses that end the game in defeat; legal range 1..7.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start/restart; level sampled each clock.
- `mapa0`..`mapa4`  in  7 each  map rows 0..4; bit c = column c; 1 = ship cell.
- `atirar`  in  1  fire request; synchronous level, internally edge-detected.
- `linha`  in  3  target row 0..4.
- `coluna`  in  3  target column 0..6.
- `acerto`, `erro`, `repetido`, `invalido`  out  1 each  one-cycle result pulses.
- `tiros0`..`tiros4`  out  7 each  cells already fired on, same bit layout as the map.
- `acertos`  out  6  count of hits.
- `erros`  out  3  count of misses.
- `restantes`  out  6  ship cells not yet hit.
- `estado`  out  2  00 OCIOSO, 01 JOGANDO, 10 VITORIA, 11 DERROTA.
- `venceu`, `perdeu`  out  1 each  levels, high in VITORIA and DERROTA respectively.

## Operation
- All outputs are registered.
- Reset values: `estado`=OCIOSO; all pulses, masks and counters 0; `venceu`=`perdeu`=0; internal map snapshot 0; `atirar` history 0.
- **`iniciar` high at an edge, any state:**
  - Load the map snapshot from `mapa0`..`mapa4`.
  - Clear `tiros*`, `acertos` and `erros`.
  - Set `restantes` = popcount of the 35 loaded bits.
  - Set `estado` = JOGANDO.
  - Later changes on the `mapa*` inputs are ignored until the next `iniciar`.
- **Shot event:** `atirar`=1 at the current edge and 0 at the previous edge. Holding `atirar` high yields exactly one shot.
- **Shots are resolved only in JOGANDO**, with `iniciar`=0. In every other state, shot events are ignored and no pulse is produced. Classification is by priority:
  1. `linha`>4 or `coluna`>6: `invalido` pulse; no other change.
  2. Cell already set in `tiros`: `repetido` pulse; no other change.
  3. Map bit 1: `acerto` pulse; set the `tiros` bit; `acertos`+1; `restantes`-1. If `restantes` goes 1→0, `estado`=VITORIA at the same edge.
  4. Map bit 0: `erro` pulse; set the `tiros` bit; `erros`+1. If `erros` reaches `MAX_ERROS`, `estado`=DERROTA at the same edge.
- **Empty map:** JOGANDO with `restantes`=0 moves to VITORIA at the next edge.
- **Terminal states:** VITORIA and DERROTA hold until `iniciar` or reset. Counters and masks stay frozen for display.
- **Simultaneous events:** `iniciar` has priority over a shot in the same cycle. The shot is discarded, but the `atirar` history still updates, so a held button does not fire afterwards.
- **Counter widths:** `restantes` never underflows and `erros` never exceeds `MAX_ERROS`; the FSM guarantees both, so no saturation logic is needed.

## Timing
- `iniciar` sampled high at edge N: new state and counters are visible after edge N (1-cycle latency).
- Shot event at edge K: the result pulse is high from edge K to edge K+1.
  - `tiros`, counters and `estado` update at edge K.
  - `linha`/`coluna` are sampled at edge K only.
- Back-to-back shots need `atirar` low for at least one sampled edge between them.
- `rst_n` low at any time, including mid-game or during a pulse: outputs go to reset values immediately.
- After `rst_n` is released, the first shot requires a fresh 0→1 on `atirar` and a preceding `iniciar`.

## Test plan
1. **Load and hit.** Load rows 0000100, 0001100, 1000101, 1110001, 1000011 → `restantes`=13, `estado`=01. Shoot (0,2) → `acerto` for 1 cycle, `tiros0`=0000100, `acertos`=1, `restantes`=12.
2. **Miss, repeat, invalid.**
   - Shoot (0,0) → `erro`, `erros`=1.
   - Shoot (0,0) again → `repetido`, counters unchanged.
   - Shoot (5,0) → `invalido`.
   - Shoot (0,7) → `invalido`.
   - Hold `atirar` high for 10 cycles → exactly one pulse.
3. **Victory.** Map `mapa0`=0000001, other rows 0 → `restantes`=1. Shoot (0,0) → `acerto`, `estado`=10, `venceu`=1. A further shot produces no pulse.
4. **Defeat.** With `MAX_ERROS`=5 and the map from scenario 1, five distinct misses → 5th `erro` pulse coincides with `estado`=11 and `perdeu`=1, `erros`=5. `iniciar` then returns to JOGANDO with counters cleared.
5. **Simultaneous `iniciar` and shot.** Assert `iniciar` and a fresh `atirar` at the same edge → no pulse, `tiros*`=0, `restantes` reloaded.
6. **Reset mid-game.** Pull `rst_n` low mid-game after 3 hits and mid-pulse → all outputs 0 and `estado`=00 without waiting for a clock edge. Shots before the next `iniciar` are ignored.
